mpu_chk_arb: RTL and testbench
==============================

// Module: mpu_chk_arb
// PURPOSE
//  Shares one mpu lookup instance between instruction fetch (IFU) and load/store (LSU) requesters.
//  Arbitrates round-robin, drives the registered paddr into mpu, evaluates the returned PMP/PMA
//  attributes against requester privilege and access type, and returns a per-requester fault/cacheable
//  response over a valid/ready handshake. Sits between IFU/LSU and the bus/cache issue stage.
// PARAMETERS
//  PADDR_W   32   physical address width; equals mpu paddr width
// PORTS
//  clk             in   1        clock
//  rst             in   1        async reset, active-high
//  if_req_valid    in   1        IFU check request
//  if_req_ready    out  1        IFU request accepted when valid&ready
//  if_req_paddr    in   PADDR_W  IFU physical address
//  if_req_prv      in   2        IFU privilege (3=M,1=S,0=U)
//  if_rsp_valid    out  1        IFU response valid
//  if_rsp_ready    in   1        IFU response consumed
//  if_rsp_fault    out  2        [0]=PMP fault, [1]=PMA fault
//  if_rsp_cache    out  1        PMA cacheable (pma_c)
//  lsu_req_valid   in   1        LSU check request
//  lsu_req_ready   out  1        LSU request accepted
//  lsu_req_paddr   in   PADDR_W  LSU physical address
//  lsu_req_prv     in   2        LSU effective privilege
//  lsu_req_wr      in   1        1=store (needs W), 0=load (needs R)
//  lsu_rsp_valid   out  1        LSU response valid
//  lsu_rsp_ready   in   1        LSU response consumed
//  lsu_rsp_fault   out  2        as IFU
//  lsu_rsp_cache   out  1        as IFU
//  mpu_paddr       out  PADDR_W  address to mpu (registered)
//  pmp_v/l/x/w/r   in   1 each   mpu PMP match/lock/perm
//  pma_v/c         in   1 each   mpu PMA match/cacheable
// BEHAVIOUR
//  FSM: IDLE -> CHK -> RSP -> IDLE. Reset: IDLE, all outputs 0, mpu_paddr=0, rr_ptr=IFU.
//  IDLE: if_req_ready/lsu_req_ready asserted only here, and only for the granted requester;
//   grant: single requester wins; both valid -> rr_ptr side wins, rr_ptr flips to the other side.
//   On accept: latch paddr->mpu_paddr, prv, access type (IFU=X, LSU wr?W:R), owner; go CHK.
//  CHK (1 cycle): mpu output is combinational on mpu_paddr; register result:
//   perm = X: pmp_x | W: pmp_w | R: pmp_r.
//   pmp_ok = (prv==3 & ~(pmp_v & pmp_l)) | (pmp_v & perm). fault[0]=~pmp_ok.
//   fault[1]=~pma_v. cache=pma_v & pma_c. Go RSP.
//  RSP: owner rsp_valid=1; fault/cache stable while valid&~ready. On rsp_ready -> IDLE, valid=0.
//   Non-owner rsp_valid stays 0; non-owner fault/cache held 0.
//  Latency: accept cycle N -> rsp_valid at N+2. Max throughput 1 check / 3 cycles.
//  prv==2 (reserved) treated as U. A requester may drop req_valid before accept; no effect.
//  req fields sampled only at accept; changes afterwards ignored.
//  mpu_paddr holds last value outside CHK; mpu config changes during CHK are sampled that cycle.
//  rst asserted mid-operation: immediate return to IDLE, pending response discarded, rr_ptr=IFU.
//  Both fault bits may be set simultaneously.
// TESTING
//  1 IFU only, prv=0, pmp_v=1,x=1,pma_v=1,c=1 -> if_rsp_valid at N+2, fault=2'b00, cache=1.
//  2 LSU store prv=1, pmp_v=1,w=0,r=1 -> lsu_rsp_fault=2'b01; same as load -> 2'b00.
//  3 M-mode load, pmp_v=0, pma_v=0 -> fault=2'b10; pmp_v=1,l=1,r=0 -> fault=2'b01.
//  4 Both valid continuously 4 checks -> grants IFU,LSU,IFU,LSU; no starvation.
//  5 rsp_ready low 5 cycles in RSP -> valid/fault/cache stable; both req_ready 0 throughout.
//  6 rst pulsed in CHK -> all outputs 0 asynchronously; next accept grants IFU first.

Source files
------------

// File: rtl/mpu_chk_arb.sv
// mpu_chk_arb: round-robin sharing of one mpu lookup between IFU and LSU,
// with PMP/PMA evaluation and per-requester valid/ready responses.
module mpu_chk_arb #(
    parameter int unsigned PADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    // IFU request / response
    input  logic               if_req_valid,
    output logic               if_req_ready,
    input  logic [PADDR_W-1:0] if_req_paddr,
    input  logic [1:0]         if_req_prv,
    output logic               if_rsp_valid,
    input  logic               if_rsp_ready,
    output logic [1:0]         if_rsp_fault,
    output logic               if_rsp_cache,
    // LSU request / response
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [PADDR_W-1:0] lsu_req_paddr,
    input  logic [1:0]         lsu_req_prv,
    input  logic               lsu_req_wr,
    output logic               lsu_rsp_valid,
    input  logic               lsu_rsp_ready,
    output logic [1:0]         lsu_rsp_fault,
    output logic               lsu_rsp_cache,
    // mpu lookup
    output logic [PADDR_W-1:0] mpu_paddr,
    input  logic               pmp_v,
    input  logic               pmp_l,
    input  logic               pmp_x,
    input  logic               pmp_w,
    input  logic               pmp_r,
    input  logic               pma_v,
    input  logic               pma_c
);

    typedef enum logic [1:0] {ST_IDLE, ST_CHK, ST_RSP} state_e;
    typedef enum logic [1:0] {ACC_X, ACC_R, ACC_W} acc_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam logic [1:0] PRV_M = 2'd3;

    state_e             state_q, state_d;
    acc_e               acc_q, acc_d;
    logic [PADDR_W-1:0] paddr_q, paddr_d;
    logic [1:0]         prv_q, prv_d;
    logic               owner_q, owner_d;
    logic               rr_q, rr_d;
    logic               if_valid_q, if_valid_d;
    logic [1:0]         if_fault_q, if_fault_d;
    logic               if_cache_q, if_cache_d;
    logic               lsu_valid_q, lsu_valid_d;
    logic [1:0]         lsu_fault_q, lsu_fault_d;
    logic               lsu_cache_q, lsu_cache_d;

    logic               if_win_c, lsu_win_c;
    logic               perm_c, pmp_ok_c, cache_c;
    logic [1:0]         fault_c;

    // Grant: lone requester wins, contention goes to the rr pointer side
    always_comb begin
        if_win_c  = (state_q == ST_IDLE) && if_req_valid
                    && (!lsu_req_valid || (rr_q == OWN_IFU));
        lsu_win_c = (state_q == ST_IDLE) && lsu_req_valid
                    && (!if_req_valid || (rr_q == OWN_LSU));
    end

    // Permission evaluation on the mpu result for the latched access
    always_comb begin
        perm_c = 1'b0;
        case (acc_q)
            ACC_X:   perm_c = pmp_x;
            ACC_W:   perm_c = pmp_w;
            ACC_R:   perm_c = pmp_r;
            default: perm_c = 1'b0;
        endcase
        // reserved prv 2 falls through as non-M, i.e. behaves like U
        pmp_ok_c = ((prv_q == PRV_M) && !(pmp_v && pmp_l)) || (pmp_v && perm_c);
        fault_c  = {~pma_v, ~pmp_ok_c};
        cache_c  = pma_v & pma_c;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        paddr_d     = paddr_q;
        prv_d       = prv_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        if_valid_d  = if_valid_q;
        if_fault_d  = if_fault_q;
        if_cache_d  = if_cache_q;
        lsu_valid_d = lsu_valid_q;
        lsu_fault_d = lsu_fault_q;
        lsu_cache_d = lsu_cache_q;

        case (state_q)
            ST_IDLE: begin
                if (if_win_c) begin
                    paddr_d = if_req_paddr;
                    prv_d   = if_req_prv;
                    acc_d   = ACC_X;
                    owner_d = OWN_IFU;
                    state_d = ST_CHK;
                    if (lsu_req_valid) rr_d = OWN_LSU;
                end else if (lsu_win_c) begin
                    paddr_d = lsu_req_paddr;
                    prv_d   = lsu_req_prv;
                    acc_d   = lsu_req_wr ? ACC_W : ACC_R;
                    owner_d = OWN_LSU;
                    state_d = ST_CHK;
                    if (if_req_valid) rr_d = OWN_IFU;
                end
            end
            ST_CHK: begin
                if (owner_q == OWN_IFU) begin
                    if_valid_d = 1'b1;
                    if_fault_d = fault_c;
                    if_cache_d = cache_c;
                end else begin
                    lsu_valid_d = 1'b1;
                    lsu_fault_d = fault_c;
                    lsu_cache_d = cache_c;
                end
                state_d = ST_RSP;
            end
            ST_RSP: begin
                if ((owner_q == OWN_IFU) && if_rsp_ready) begin
                    if_valid_d = 1'b0;
                    if_fault_d = 2'b00;
                    if_cache_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if ((owner_q == OWN_LSU) && lsu_rsp_ready) begin
                    lsu_valid_d = 1'b0;
                    lsu_fault_d = 2'b00;
                    lsu_cache_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= ACC_X;
            paddr_q     <= '0;
            prv_q       <= 2'b00;
            owner_q     <= OWN_IFU;
            rr_q        <= OWN_IFU;
            if_valid_q  <= 1'b0;
            if_fault_q  <= 2'b00;
            if_cache_q  <= 1'b0;
            lsu_valid_q <= 1'b0;
            lsu_fault_q <= 2'b00;
            lsu_cache_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            paddr_q     <= paddr_d;
            prv_q       <= prv_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            if_valid_q  <= if_valid_d;
            if_fault_q  <= if_fault_d;
            if_cache_q  <= if_cache_d;
            lsu_valid_q <= lsu_valid_d;
            lsu_fault_q <= lsu_fault_d;
            lsu_cache_q <= lsu_cache_d;
        end
    end

    assign if_req_ready  = if_win_c;
    assign lsu_req_ready = lsu_win_c;
    assign mpu_paddr     = paddr_q;
    assign if_rsp_valid  = if_valid_q;
    assign if_rsp_fault  = if_fault_q;
    assign if_rsp_cache  = if_cache_q;
    assign lsu_rsp_valid = lsu_valid_q;
    assign lsu_rsp_fault = lsu_fault_q;
    assign lsu_rsp_cache = lsu_cache_q;

endmodule

// File: tb/tb_mpu_chk_arb.sv
// Directed bench for mpu_chk_arb: stimulus driven at negedge, outputs sampled 1ns later.
module tb_mpu_chk_arb;

    logic        clk, rst;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_paddr;
    logic [1:0]  if_req_prv;
    logic        if_rsp_valid, if_rsp_ready;
    logic [1:0]  if_rsp_fault;
    logic        if_rsp_cache;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_paddr;
    logic [1:0]  lsu_req_prv;
    logic        lsu_req_wr;
    logic        lsu_rsp_valid, lsu_rsp_ready;
    logic [1:0]  lsu_rsp_fault;
    logic        lsu_rsp_cache;
    logic [31:0] mpu_paddr;
    logic        pmp_v, pmp_l, pmp_x, pmp_w, pmp_r, pma_v, pma_c;

    int compared = 0;
    int mismatched = 0;

    mpu_chk_arb #(.PADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_paddr(if_req_paddr), .if_req_prv(if_req_prv),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_fault(if_rsp_fault), .if_rsp_cache(if_rsp_cache),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_paddr(lsu_req_paddr), .lsu_req_prv(lsu_req_prv),
        .lsu_req_wr(lsu_req_wr),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_fault(lsu_rsp_fault), .lsu_rsp_cache(lsu_rsp_cache),
        .mpu_paddr(mpu_paddr),
        .pmp_v(pmp_v), .pmp_l(pmp_l), .pmp_x(pmp_x), .pmp_w(pmp_w), .pmp_r(pmp_r),
        .pma_v(pma_v), .pma_c(pma_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_mpu(input logic v, l, x, w, r, pv, pc);
        pmp_v = v; pmp_l = l; pmp_x = x; pmp_w = w; pmp_r = r; pma_v = pv; pma_c = pc;
    endtask

    // One uncontended transaction; lat = cycles from accept cycle to rsp_valid, -1 on timeout
    task automatic run_one(input bit lsu, input logic [31:0] pa, input logic [1:0] prv,
                           input logic wr, output logic [1:0] f, output logic c, output int lat);
        int n;
        f = 2'b00; c = 1'b0; lat = -1;
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_req_paddr = pa; lsu_req_prv = prv; lsu_req_wr = wr;
        end else begin
            if_req_valid = 1'b1; if_req_paddr = pa; if_req_prv = prv;
        end
        #1;
        n = 0;
        while (!(lsu ? lsu_req_ready : if_req_ready) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 10) begin
            if_req_valid = 1'b0; lsu_req_valid = 1'b0;
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
            #1;
        end while (!(lsu ? lsu_rsp_valid : if_rsp_valid) && n < 10);
        if (lsu ? lsu_rsp_valid : if_rsp_valid) begin
            lat = n;
            f = lsu ? lsu_rsp_fault : if_rsp_fault;
            c = lsu ? lsu_rsp_cache : if_rsp_cache;
        end
        if (lsu) lsu_rsp_ready = 1'b1; else if_rsp_ready = 1'b1;
        @(negedge clk);
        if_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_valid = 0; if_req_paddr = '0; if_req_prv = 0; if_rsp_ready = 0;
        lsu_req_valid = 0; lsu_req_paddr = '0; lsu_req_prv = 0; lsu_req_wr = 0; lsu_rsp_ready = 0;
        set_mpu(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk); #1;
        compared++;
        if ({if_rsp_valid, lsu_rsp_valid, if_rsp_fault, lsu_rsp_fault, if_rsp_cache, lsu_rsp_cache} !== 8'h00) begin
            mismatched++; $display("FAIL reset_outs got=%b required=0",
                {if_rsp_valid, lsu_rsp_valid, if_rsp_fault, lsu_rsp_fault, if_rsp_cache, lsu_rsp_cache});
        end
        compared++;
        if (mpu_paddr !== 32'h0) begin
            mismatched++; $display("FAIL reset_paddr got=%h required=0", mpu_paddr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ifu();
        logic [1:0] f; logic c; int lat;
        set_mpu(1, 0, 1, 0, 0, 1, 1);
        run_one(1'b0, 32'h0000_1000, 2'd0, 1'b0, f, c, lat);
        compared++; if (lat !== 2) begin mismatched++; $display("FAIL ifu_latency got=%0d required=2", lat); end
        compared++; if (f !== 2'b00) begin mismatched++; $display("FAIL ifu_fault got=%b required=00", f); end
        compared++; if (c !== 1'b1) begin mismatched++; $display("FAIL ifu_cache got=%b required=1", c); end
        compared++; if (mpu_paddr !== 32'h0000_1000) begin
            mismatched++; $display("FAIL ifu_paddr_hold got=%h required=00001000", mpu_paddr); end
        compared++; if (lsu_rsp_valid !== 1'b0) begin
            mismatched++; $display("FAIL ifu_lsu_idle got=%b required=0", lsu_rsp_valid); end
        set_mpu(1, 0, 0, 1, 1, 1, 1);
        run_one(1'b0, 32'h0000_1004, 2'd0, 1'b0, f, c, lat);
        compared++; if (f !== 2'b01) begin mismatched++; $display("FAIL ifu_nox_fault got=%b required=01", f); end
        set_mpu(0, 0, 0, 0, 0, 1, 0);
        run_one(1'b0, 32'h0000_1008, 2'd3, 1'b0, f, c, lat);
        compared++; if (f !== 2'b00) begin mismatched++; $display("FAIL ifu_m_nomatch got=%b required=00", f); end
        compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL ifu_m_cache got=%b required=0", c); end
    endtask

    task automatic test_lsu_perm();
        logic [1:0] f; logic c; int lat;
        set_mpu(1, 0, 0, 0, 1, 1, 0);
        run_one(1'b1, 32'h0000_2000, 2'd1, 1'b1, f, c, lat);
        compared++; if (lat !== 2) begin mismatched++; $display("FAIL lsu_latency got=%0d required=2", lat); end
        compared++; if (f !== 2'b01) begin mismatched++; $display("FAIL lsu_store_fault got=%b required=01", f); end
        run_one(1'b1, 32'h0000_2000, 2'd1, 1'b0, f, c, lat);
        compared++; if (f !== 2'b00) begin mismatched++; $display("FAIL lsu_load_fault got=%b required=00", f); end
        compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL lsu_load_cache got=%b required=0", c); end
    endtask

    task automatic test_mmode();
        logic [1:0] f; logic c; int lat;
        set_mpu(0, 0, 0, 0, 0, 0, 1);
        run_one(1'b1, 32'h0000_3000, 2'd3, 1'b0, f, c, lat);
        compared++; if (f !== 2'b10) begin mismatched++; $display("FAIL m_nopma got=%b required=10", f); end
        compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL m_nopma_cache got=%b required=0", c); end
        set_mpu(1, 1, 0, 0, 0, 1, 1);
        run_one(1'b1, 32'h0000_3004, 2'd3, 1'b0, f, c, lat);
        compared++; if (f !== 2'b01) begin mismatched++; $display("FAIL m_locked got=%b required=01", f); end
        set_mpu(1, 1, 0, 0, 0, 0, 1);
        run_one(1'b1, 32'h0000_3008, 2'd3, 1'b0, f, c, lat);
        compared++; if (f !== 2'b11) begin mismatched++; $display("FAIL both_faults got=%b required=11", f); end
        set_mpu(0, 0, 0, 0, 0, 1, 1);
        run_one(1'b1, 32'h0000_300C, 2'd2, 1'b0, f, c, lat);
        compared++; if (f !== 2'b01) begin mismatched++; $display("FAIL prv2_as_u got=%b required=01", f); end
        set_mpu(1, 0, 0, 0, 0, 1, 1);
        run_one(1'b1, 32'h0000_3010, 2'd3, 1'b1, f, c, lat);
        compared++; if (f !== 2'b00) begin mismatched++; $display("FAIL m_unlocked_store got=%b required=00", f); end
    endtask

    task automatic test_round_robin();
        int g, cyc;
        logic got;
        set_mpu(1, 0, 1, 1, 1, 1, 1);
        if_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
        if_req_valid = 1'b1; if_req_paddr = 32'h0000_4000; if_req_prv = 2'd0;
        lsu_req_valid = 1'b1; lsu_req_paddr = 32'h0000_5000; lsu_req_prv = 2'd0; lsu_req_wr = 1'b0;
        g = 0; cyc = 0;
        while (g < 4 && cyc < 40) begin
            #1;
            if (if_req_ready || lsu_req_ready) begin
                got = lsu_req_ready;
                compared++;
                if (if_req_ready && lsu_req_ready) begin
                    mismatched++; $display("FAIL rr_dual_grant grant=%0d both ready", g);
                end
                compared++;
                if (got !== g[0]) begin
                    mismatched++; $display("FAIL rr_order grant=%0d got_lsu=%b required_lsu=%b", g, got, g[0]);
                end
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        compared++;
        if (g != 4) begin mismatched++; $display("FAIL rr_timeout grants=%0d required=4", g); end
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        if_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        set_mpu(1, 0, 0, 1, 1, 1, 1);
        if_req_valid = 1'b1; if_req_paddr = 32'h0000_6000; if_req_prv = 2'd0;
        #1;
        compared++; if (if_req_ready !== 1'b1) begin
            mismatched++; $display("FAIL bp_grant got=%b required=1", if_req_ready); end
        @(negedge clk);
        if_req_valid = 1'b0; if_req_paddr = 32'hDEAD_0000;
        lsu_req_valid = 1'b1; lsu_req_paddr = 32'h0000_7000; lsu_req_wr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            compared++; if (if_rsp_valid !== 1'b1) begin
                mismatched++; $display("FAIL bp_valid cyc=%0d got=%b required=1", i, if_rsp_valid); end
            compared++; if ({if_rsp_fault, if_rsp_cache} !== 3'b011) begin
                mismatched++; $display("FAIL bp_stable cyc=%0d got=%b required=011", i, {if_rsp_fault, if_rsp_cache}); end
            compared++; if ({if_req_ready, lsu_req_ready} !== 2'b00) begin
                mismatched++; $display("FAIL bp_ready cyc=%0d got=%b required=00", i, {if_req_ready, lsu_req_ready}); end
            compared++; if ({lsu_rsp_valid, lsu_rsp_fault, lsu_rsp_cache} !== 4'b0000) begin
                mismatched++; $display("FAIL bp_nonowner cyc=%0d got=%b required=0000", i,
                    {lsu_rsp_valid, lsu_rsp_fault, lsu_rsp_cache}); end
            compared++; if (mpu_paddr !== 32'h0000_6000) begin
                mismatched++; $display("FAIL bp_paddr cyc=%0d got=%h required=00006000", i, mpu_paddr); end
            pmp_x = 1'b1; pma_v = 1'b0;
            @(negedge clk);
        end
        lsu_req_valid = 1'b0;
        if_rsp_ready = 1'b1;
        @(negedge clk);
        if_rsp_ready = 1'b0;
        #1;
        compared++; if ({if_rsp_valid, if_rsp_fault, if_rsp_cache} !== 4'b0000) begin
            mismatched++; $display("FAIL bp_release got=%b required=0000", {if_rsp_valid, if_rsp_fault, if_rsp_cache}); end
    endtask

    task automatic test_reset_in_chk();
        set_mpu(1, 0, 1, 1, 1, 1, 1);
        @(negedge clk);
        if_req_valid = 1'b1; if_req_paddr = 32'h0000_8000; if_req_prv = 2'd0;
        lsu_req_valid = 1'b1; lsu_req_paddr = 32'h0000_9000; lsu_req_wr = 1'b0;
        #1;
        compared++; if ({if_req_ready, lsu_req_ready} !== 2'b10) begin
            mismatched++; $display("FAIL rst_pre_grant got=%b required=10", {if_req_ready, lsu_req_ready}); end
        @(negedge clk);
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        compared++; if (mpu_paddr !== 32'h0000_8000) begin
            mismatched++; $display("FAIL rst_chk_paddr got=%h required=00008000", mpu_paddr); end
        #1 rst = 1'b1;
        #1;
        compared++; if ({if_rsp_valid, lsu_rsp_valid, if_rsp_fault, lsu_rsp_fault, if_rsp_cache, lsu_rsp_cache,
                         if_req_ready, lsu_req_ready} !== 10'h000) begin
            mismatched++; $display("FAIL rst_async_outs got=%b required=0", {if_rsp_valid, lsu_rsp_valid,
                if_rsp_fault, lsu_rsp_fault, if_rsp_cache, lsu_rsp_cache, if_req_ready, lsu_req_ready}); end
        compared++; if (mpu_paddr !== 32'h0) begin
            mismatched++; $display("FAIL rst_async_paddr got=%h required=0", mpu_paddr); end
        #1 rst = 1'b0;
        @(negedge clk); #1;
        compared++; if (if_rsp_valid !== 1'b0) begin
            mismatched++; $display("FAIL rst_discard got=%b required=0", if_rsp_valid); end
        if_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        compared++; if ({if_req_ready, lsu_req_ready} !== 2'b10) begin
            mismatched++; $display("FAIL rst_rr_ifu got=%b required=10", {if_req_ready, lsu_req_ready}); end
        @(negedge clk);
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        if_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        if_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifu();
        test_lsu_perm();
        test_mmode();
        test_round_robin();
        test_backpressure();
        test_reset_in_chk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
